conv_input_streamer: RTL and testbench

Transmit side of the a_input/b_input valid/ready stream consumed by top_chip. Reads operand pairs from the external memory (feature word and kernel word at the same address) and presents them to the chip one pair per handshake. Sits in top_system between the external memory model and top_chip. Every beat it delivers is counted toward chip input bandwidth.

---
 rtl/conv_input_streamer_if.sv | 23 ++
 rtl/conv_input_streamer.sv | 124 ++++++++++++
 tb/tb_conv_input_streamer.sv | 218 +++++++++++++++++++++
 3 files changed

// File: rtl/conv_input_streamer_if.sv
// Operand-pair stream towards top_chip: one {a_input, b_input} pair per valid/ready beat.
interface conv_input_streamer_if #(
  parameter int unsigned IO_DATA_WIDTH = 16
);
  logic [IO_DATA_WIDTH-1:0] a_input;
  logic [IO_DATA_WIDTH-1:0] b_input;
  logic                     a_valid;
  logic                     a_ready;

  modport master (
    output a_input,
    output b_input,
    output a_valid,
    input  a_ready
  );

  modport slave (
    input  a_input,
    input  b_input,
    input  a_valid,
    output a_ready
  );
endinterface

// File: rtl/conv_input_streamer.sv
// Reads feature/kernel pairs from external memory and streams them to the chip through a
// 3-entry buffer, issuing reads from registered credit so a_ready never reaches mem_re.
module conv_input_streamer #(
  parameter int unsigned IO_DATA_WIDTH = 16,
  parameter int unsigned ADDR_WIDTH    = 20,
  parameter int unsigned FIFO_DEPTH    = 3
) (
  input  logic                     clk,
  input  logic                     arst_n_in,
  input  logic                     start,
  input  logic [ADDR_WIDTH:0]      nb_words,
  output logic                     mem_re,
  output logic [ADDR_WIDTH-1:0]    mem_addr,
  input  logic [IO_DATA_WIDTH-1:0] mem_a_rdata,
  input  logic [IO_DATA_WIDTH-1:0] mem_b_rdata,
  conv_input_streamer_if.master    chip_if,
  output logic                     running,
  output logic                     done,
  output logic [ADDR_WIDTH:0]      words_sent
);

  typedef enum logic [0:0] {StIdle, StStream} state_e;

  state_e                       state_q, state_d;
  logic [ADDR_WIDTH:0]          nb_q, nb_d;
  logic [ADDR_WIDTH:0]          issued_q, issued_d;
  logic [ADDR_WIDTH:0]          words_sent_q, words_sent_d;
  logic [ADDR_WIDTH:0]          words_sent_inc;
  logic                         done_q, done_d;
  logic                         inflight_q;
  logic [1:0]                   count_q, count_d;
  logic [1:0]                   wr_ptr_q, rd_ptr_q;
  logic [2*IO_DATA_WIDTH-1:0]   fifo_q [FIFO_DEPTH];
  logic [2:0]                   credit_used;
  logic                         issue, push, pop;

  // Buffered entries plus the read still in flight must fit in the buffer.
  assign credit_used    = {1'b0, count_q} + {2'b00, inflight_q};
  assign issue          = (state_q == StStream) && (issued_q < nb_q) &&
                          (credit_used < 3'(FIFO_DEPTH));
  assign push           = inflight_q;
  assign pop            = chip_if.a_valid && chip_if.a_ready;
  assign words_sent_inc = words_sent_q + 1'b1;

  assign mem_re          = issue;
  assign mem_addr        = issue ? issued_q[ADDR_WIDTH-1:0] : '0;
  assign chip_if.a_valid = (count_q != 2'd0);
  assign chip_if.a_input = fifo_q[rd_ptr_q][2*IO_DATA_WIDTH-1:IO_DATA_WIDTH];
  assign chip_if.b_input = fifo_q[rd_ptr_q][IO_DATA_WIDTH-1:0];
  assign running         = (state_q == StStream);
  assign done            = done_q;
  assign words_sent      = words_sent_q;

  always_comb begin
    state_d      = state_q;
    nb_d         = nb_q;
    issued_d     = issued_q;
    words_sent_d = words_sent_q;
    done_d       = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          words_sent_d = '0;
          if (nb_words != '0) begin
            nb_d     = nb_words;
            issued_d = '0;
            state_d  = StStream;
          end else begin
            done_d = 1'b1;
          end
        end
      end
      StStream: begin
        if (issue) issued_d = issued_q + 1'b1;
        if (pop && (words_sent_q != nb_q)) words_sent_d = words_sent_inc;
        if (pop && (words_sent_inc == nb_q)) begin
          done_d  = 1'b1;
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    count_d = count_q;
    unique case ({push, pop})
      2'b10:   count_d = count_q + 2'd1;
      2'b01:   count_d = count_q - 2'd1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or negedge arst_n_in) begin
    if (!arst_n_in) begin
      state_q      <= StIdle;
      nb_q         <= '0;
      issued_q     <= '0;
      words_sent_q <= '0;
      done_q       <= 1'b0;
      inflight_q   <= 1'b0;
      count_q      <= '0;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      for (int i = 0; i < int'(FIFO_DEPTH); i++) fifo_q[i] <= '0;
    end else begin
      state_q      <= state_d;
      nb_q         <= nb_d;
      issued_q     <= issued_d;
      words_sent_q <= words_sent_d;
      done_q       <= done_d;
      inflight_q   <= issue;
      count_q      <= count_d;
      if (push) begin
        fifo_q[wr_ptr_q] <= {mem_a_rdata, mem_b_rdata};
        wr_ptr_q         <= (wr_ptr_q == 2'(FIFO_DEPTH - 1)) ? 2'd0 : wr_ptr_q + 2'd1;
      end
      if (pop) begin
        rd_ptr_q <= (rd_ptr_q == 2'(FIFO_DEPTH - 1)) ? 2'd0 : rd_ptr_q + 2'd1;
      end
    end
  end

endmodule

// File: tb/tb_conv_input_streamer.sv
// Directed bench for conv_input_streamer with a 1-cycle-latency memory model (a=0x100+i, b=0x200+i).
module tb_conv_input_streamer;

  localparam int unsigned DW = 16;
  localparam int unsigned AW = 4;

  logic          clk = 1'b0;
  logic          arst_n_in;
  logic          start;
  logic [AW:0]   nb_words;
  logic          mem_re;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_a_rdata;
  logic [DW-1:0] mem_b_rdata;
  logic          running;
  logic          done;
  logic [AW:0]   words_sent;

  conv_input_streamer_if #(.IO_DATA_WIDTH(DW)) sif ();

  conv_input_streamer #(
    .IO_DATA_WIDTH(DW),
    .ADDR_WIDTH   (AW),
    .FIFO_DEPTH   (3)
  ) dut (
    .clk        (clk),
    .arst_n_in  (arst_n_in),
    .start      (start),
    .nb_words   (nb_words),
    .mem_re     (mem_re),
    .mem_addr   (mem_addr),
    .mem_a_rdata(mem_a_rdata),
    .mem_b_rdata(mem_b_rdata),
    .chip_if    (sif.master),
    .running    (running),
    .done       (done),
    .words_sent (words_sent)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (mem_re) begin
      mem_a_rdata <= 16'h0100 + 16'(mem_addr);
      mem_b_rdata <= 16'h0200 + 16'(mem_addr);
    end
  end

  int checks = 0;
  int errors = 0;

  logic [DW-1:0] beat_a [$];
  logic [DW-1:0] beat_b [$];
  int            addr_q [$];

  // mode: 0 always ready, 1 stall 5 cycles after first valid, 2 random, 3 alternating
  typedef struct {
    int nb;
    int mode;
    int inject;
    int exp_words;
    int exp_done;
    int exp_lat;   // -2 = don't care, -1 = a_valid must never rise
  } vec_t;

  vec_t vecs [6];

  task automatic chk(input string name, input longint got, input longint exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
    end
  endtask

  task automatic chk_idle_zero(input string tag);
    chk({tag, "_mem_re"},     mem_re,      0);
    chk({tag, "_mem_addr"},   mem_addr,    0);
    chk({tag, "_a_valid"},    sif.a_valid, 0);
    chk({tag, "_a_input"},    sif.a_input, 0);
    chk({tag, "_b_input"},    sif.b_input, 0);
    chk({tag, "_running"},    running,     0);
    chk({tag, "_done"},       done,        0);
    chk({tag, "_words_sent"}, words_sent,  0);
  endtask

  task automatic run_xfer(input vec_t v);
    int            first_valid = -1;
    int            done_cnt = 0;
    int            done_cyc = -1;
    int            cyc = 0;
    bit            timed_out = 0;
    bit            prev_hold = 0;
    bit            r;
    logic [DW-1:0] ha = '0;
    logic [DW-1:0] hb = '0;
    int            n;
    beat_a.delete();
    beat_b.delete();
    addr_q.delete();
    start    = 1'b1;
    nb_words = 5'(v.nb);
    sif.a_ready = (v.mode == 0);
    @(posedge clk); #1;
    start = 1'b0;
    while (1) begin
      if (done) begin
        done_cnt++;
        if (done_cyc < 0) done_cyc = cyc;
      end
      if (mem_re) addr_q.push_back(int'(mem_addr));
      if (prev_hold) begin
        chk("hold_valid", sif.a_valid, 1);
        chk("hold_a", sif.a_input, ha);
        chk("hold_b", sif.b_input, hb);
      end
      if (sif.a_valid && first_valid < 0) first_valid = cyc;
      if (v.mode == 1 && first_valid >= 0 && cyc == first_valid + 4)
        chk("stall_outstanding_reads", addr_q.size(), 3);
      case (v.mode)
        0:       r = 1'b1;
        1:       r = !(first_valid >= 0 && cyc < first_valid + 5);
        2:       r = 1'($urandom_range(0, 1));
        default: r = ((cyc % 2) == 1);
      endcase
      sif.a_ready = r;
      if (v.inject != 0 && cyc == 3) begin
        start    = 1'b1;
        nb_words = 5'(v.inject);
      end else begin
        start = 1'b0;
      end
      prev_hold = sif.a_valid && !r;
      ha = sif.a_input;
      hb = sif.b_input;
      if (sif.a_valid && r) begin
        beat_a.push_back(sif.a_input);
        beat_b.push_back(sif.b_input);
      end
      if (done_cyc >= 0 && cyc >= done_cyc + 2) break;
      if (cyc >= 300) begin
        timed_out = 1;
        break;
      end
      @(posedge clk); #1;
      cyc++;
    end
    start = 1'b0;
    sif.a_ready = 1'b0;
    chk("timeout", timed_out, 0);
    chk("beat_count", beat_a.size(), v.exp_words);
    n = (beat_a.size() < v.exp_words) ? beat_a.size() : v.exp_words;
    for (int i = 0; i < n; i++) begin
      chk("beat_a", beat_a[i], 16'h0100 + 16'(i));
      chk("beat_b", beat_b[i], 16'h0200 + 16'(i));
    end
    chk("read_count", addr_q.size(), v.nb);
    n = (addr_q.size() < v.nb) ? addr_q.size() : v.nb;
    for (int i = 0; i < n; i++) chk("read_addr", addr_q[i], i);
    chk("done_pulses", done_cnt, v.exp_done);
    chk("words_sent", words_sent, v.exp_words);
    chk("running_end", running, 0);
    chk("a_valid_end", sif.a_valid, 0);
    if (v.exp_lat != -2) chk("first_valid_latency", first_valid, v.exp_lat);
    if (v.mode == 0 && v.nb > 0) chk("back_to_back_done", done_cyc, first_valid + v.nb);
  endtask

  initial begin
    int nbeats;
    int guard;
    vecs[0] = '{nb: 4,  mode: 0, inject: 0, exp_words: 4,  exp_done: 1, exp_lat: 2};
    vecs[1] = '{nb: 8,  mode: 1, inject: 0, exp_words: 8,  exp_done: 1, exp_lat: 2};
    vecs[2] = '{nb: 0,  mode: 0, inject: 0, exp_words: 0,  exp_done: 1, exp_lat: -1};
    vecs[3] = '{nb: 6,  mode: 0, inject: 2, exp_words: 6,  exp_done: 1, exp_lat: 2};
    vecs[4] = '{nb: 16, mode: 2, inject: 0, exp_words: 16, exp_done: 1, exp_lat: -2};
    vecs[5] = '{nb: 1,  mode: 3, inject: 0, exp_words: 1,  exp_done: 1, exp_lat: 2};

    arst_n_in   = 1'b0;
    start       = 1'b0;
    nb_words    = '0;
    sif.a_ready = 1'b0;
    #1;
    chk_idle_zero("reset");
    repeat (2) @(posedge clk);
    #1;
    arst_n_in = 1'b1;

    for (int k = 0; k < 6; k++) run_xfer(vecs[k]);

    // Abort after the second beat of an 8-beat transfer, then restart cleanly.
    start       = 1'b1;
    nb_words    = 5'd8;
    sif.a_ready = 1'b1;
    @(posedge clk); #1;
    start  = 1'b0;
    nbeats = 0;
    guard  = 0;
    while (nbeats < 2 && guard < 50) begin
      if (sif.a_valid) nbeats++;
      @(posedge clk); #1;
      guard++;
    end
    chk("abort_reached_beat2", nbeats, 2);
    chk("abort_running_before", running, 1);
    arst_n_in   = 1'b0;
    sif.a_ready = 1'b0;
    #1;
    chk_idle_zero("abort");
    @(posedge clk); #1;
    chk("abort_no_done", done, 0);
    arst_n_in = 1'b1;
    run_xfer('{nb: 3, mode: 0, inject: 0, exp_words: 3, exp_done: 1, exp_lat: 2});

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
